// File: rtl/bidir_arb_pkg.sv
// Shared constants for the bidir pad bank arbiter: FSM state encodings,
// the pad configuration used whenever nobody owns the bank, and a small
// width helper for counters and indices.
package bidir_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_TURN  = 2'd1;
    localparam arb_state_t ST_OWNED = 2'd2;

    // Safe bank configuration: nothing driven, inputs enabled, pulled down.
    localparam logic IDLE_OUT = 1'b0;
    localparam logic IDLE_OE  = 1'b0;
    localparam logic IDLE_CS  = 1'b0;
    localparam logic IDLE_SL  = 1'b0;
    localparam logic IDLE_IE  = 1'b1;
    localparam logic IDLE_PU  = 1'b0;
    localparam logic IDLE_PD  = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the lowest eligible index at or after
// ptr wins, wrapping around. mask removes requesters from consideration
// (used to exclude the current owner when looking for a contender).
module rr_pick
    import bidir_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               valid,
    output logic [NUM_REQ-1:0] pick
);

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   idx;

    assign elig = req & ~mask;

    // Walk the requesters starting at ptr and take the first eligible one.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && elig[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bidir_pad_arbiter.sv
// Shares one bidir pad bank between NUM_REQ requesters. Ownership changes
// always pass through a window with every OE low (TURN state, or a single
// IDLE-config edge when TURN_CYCLES is 0), so two requesters never drive
// the pads at once. Pad controls are registered and lag the owner by one
// cycle; they drop to the idle config on the same edge that grant falls.
// Requesters hold req as a level and must stop driving when grant is 0.
module bidir_pad_arbiter
    import bidir_arb_pkg::*;
#(
    parameter int NUM_BIDIR_PADS = 40,
    parameter int NUM_REQ        = 4,
    parameter int TURN_CYCLES    = 2,
    parameter int MAX_HOLD       = 256
) (
    input  logic                                clk60,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    output logic [NUM_REQ-1:0]                  grant,
    input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0]   req_out,
    input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0]   req_oe,
    input  logic [NUM_REQ*4-1:0]                req_cfg,
    output logic [NUM_REQ*NUM_BIDIR_PADS-1:0]   req_in,
    input  logic [NUM_BIDIR_PADS-1:0]           bidir_in,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_out,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0]           bidir_pd,
    output logic [1:0]                          fsm_state
);

    localparam int N      = NUM_BIDIR_PADS;
    localparam int IDX_W  = cnt_w(NUM_REQ);
    localparam int TC_W   = cnt_w(TURN_CYCLES);
    localparam int HOLD_W = cnt_w(MAX_HOLD);

    localparam logic [TC_W-1:0]   TURN_LOAD = TC_W'(TURN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   nxt;        // pending requester in TURN, owner in OWNED
    logic [IDX_W-1:0]   rr_ptr;
    logic [TC_W-1:0]    turn_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_after_nxt;
    logic [IDX_W-1:0]   ptr_after_pick;
    logic               preempt;
    logic               leave;
    logic [N-1:0]       owner_out;
    logic [N-1:0]       owner_oe;
    logic [3:0]         owner_cfg;

    assign fsm_state = state;

    // grant is one-hot on the owner in OWNED and zero otherwise, so it is
    // exactly the mask that keeps the owner out of contender selection.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .mask  (grant),
        .valid (pick_valid),
        .pick  (pick_oh)
    );

    // Convert the one-hot pick into an index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    assign ptr_after_nxt  = (nxt == LAST_IDX) ? '0 : nxt + 1'b1;
    assign ptr_after_pick = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

    // Preemption needs a contender; a lone holder is never kicked off.
    assign preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && pick_valid;
    assign leave   = (state == ST_OWNED) && (!req[nxt] || preempt);

    assign owner_out = req_out[int'(nxt)*N +: N];
    assign owner_oe  = req_oe[int'(nxt)*N +: N];
    assign owner_cfg = req_cfg[int'(nxt)*4 +: 4];

    // Ownership FSM: arbitration, turnaround countdown, hold timer.
    always_ff @(posedge clk60 or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            nxt      <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        nxt <= pick_idx;
                        if (TURN_CYCLES == 0) begin
                            state    <= ST_OWNED;
                            grant    <= pick_oh;
                            hold_cnt <= '0;
                            rr_ptr   <= ptr_after_pick;
                        end else begin
                            state    <= ST_TURN;
                            turn_cnt <= TURN_LOAD;
                        end
                    end
                end
                ST_TURN: begin
                    if (!req[nxt]) begin
                        state <= ST_IDLE;
                    end else if (turn_cnt == '0) begin
                        state    <= ST_OWNED;
                        grant    <= NUM_REQ'(1) << nxt;
                        hold_cnt <= '0;
                        rr_ptr   <= ptr_after_nxt;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                ST_OWNED: begin
                    if (leave) begin
                        grant <= '0;
                        // With no turnaround the handoff goes via IDLE so
                        // the bank still sees one idle-config edge.
                        if (pick_valid && (TURN_CYCLES != 0)) begin
                            state    <= ST_TURN;
                            nxt      <= pick_idx;
                            turn_cnt <= TURN_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Pad registers: follow the owner while it keeps the bank, idle otherwise.
    always_ff @(posedge clk60 or posedge rst) begin
        if (rst) begin
            bidir_out <= {N{IDLE_OUT}};
            bidir_oe  <= {N{IDLE_OE}};
            bidir_cs  <= {N{IDLE_CS}};
            bidir_sl  <= {N{IDLE_SL}};
            bidir_ie  <= {N{IDLE_IE}};
            bidir_pu  <= {N{IDLE_PU}};
            bidir_pd  <= {N{IDLE_PD}};
        end else if ((state == ST_OWNED) && !leave) begin
            bidir_out <= owner_out;
            bidir_oe  <= owner_oe;
            bidir_cs  <= {N{owner_cfg[3]}};
            bidir_sl  <= {N{owner_cfg[2]}};
            bidir_ie  <= {N{1'b1}};
            bidir_pu  <= {N{owner_cfg[1]}};
            bidir_pd  <= {N{owner_cfg[0]}};
        end else begin
            bidir_out <= {N{IDLE_OUT}};
            bidir_oe  <= {N{IDLE_OE}};
            bidir_cs  <= {N{IDLE_CS}};
            bidir_sl  <= {N{IDLE_SL}};
            bidir_ie  <= {N{IDLE_IE}};
            bidir_pu  <= {N{IDLE_PU}};
            bidir_pd  <= {N{IDLE_PD}};
        end
    end

    // Pad input goes only to the owner's slice; everyone else sees zero.
    always_comb begin
        req_in = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_in[r*N +: N] = grant[r] ? bidir_in : '0;
        end
    end

endmodule
